// File: rtl/chunked_wide_adder_pkg.sv
// ---------------------------------------------------------------------------
// wide_add_pkg
//   Shared types and helpers for chunked_wide_adder.
//   - wide_add_state_t : sequencing FSM state (IDLE -> RUN -> DONE -> IDLE)
//   - chunk_cnt_width  : width of the chunk counter, never narrower than 1 bit
// ---------------------------------------------------------------------------
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wide_add_state_t;

    function automatic int unsigned chunk_cnt_width(input int unsigned n_chunks);
        return (n_chunks <= 1) ? 1 : $clog2(n_chunks);
    endfunction

endpackage

// File: rtl/chunked_wide_adder_if.sv
// ---------------------------------------------------------------------------
// chunked_wide_adder_if
//   Operand / result handshake bundle of chunked_wide_adder.
//   Parameter W : full operand width (N_BIT * N_CHUNKS of the adder).
//   Signals:
//     in_valid, in_ready            input-side handshake
//     operand_1, operand_2 [W]      operands, sampled at the accept edge
//     carry_in                      carry into bit 0
//     out_valid, out_ready          output-side handshake
//     sum [W], carry_out, overflow  registered result
//   Modports: master = producer/consumer side, slave = the adder.
// ---------------------------------------------------------------------------
interface chunked_wide_adder_if #(
    parameter int unsigned W = 128
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] operand_1;
    logic [W-1:0] operand_2;
    logic         carry_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    modport master (
        output in_valid, operand_1, operand_2, carry_in, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );

    modport slave (
        input  in_valid, operand_1, operand_2, carry_in, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );

endinterface

// File: rtl/chunked_wide_adder_sparse_tree_adder.sv
// ---------------------------------------------------------------------------
// sparse_tree_adder
//   Combinational N_BIT adder. Carries are computed by a Kogge-Stone prefix
//   tree only at 4-bit block boundaries; inside each block the sum bits are
//   rippled from the block's carry-in.
//   Ports:
//     clk        in   1      present for interface compatibility, unused
//     a, b       in   N_BIT  addends
//     carry_in   in   1      carry into bit 0
//     sum        out  N_BIT  a + b + carry_in (mod 2^N_BIT)
//     carry_out  out  1      carry out of bit N_BIT-1
//     overflow   out  1      signed overflow (carry into MSB xor carry out)
// ---------------------------------------------------------------------------
module sparse_tree_adder #(
    parameter int unsigned N_BIT = 32
) (
    input  logic             clk,
    input  logic [N_BIT-1:0] a,
    input  logic [N_BIT-1:0] b,
    input  logic             carry_in,
    output logic [N_BIT-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NB   = int'(N_BIT);
    localparam int BLK  = 4;
    localparam int NBLK = (NB + BLK - 1) / BLK;
    localparam int PW   = NBLK * BLK;

    // The tree is purely combinational; the clock is not needed.
    logic unused_clk;
    assign unused_clk = clk;

    // Pad bits: generate=0, propagate=1, so they pass carries through untouched.
    logic [PW-1:0] g_pad;
    logic [PW-1:0] p_pad;
    assign g_pad = PW'(a & b);
    assign p_pad = ~PW'(~(a ^ b));

    logic [NBLK-1:0] blk_g;
    logic [NBLK-1:0] blk_p;
    logic [NBLK-1:0] pre_g;
    logic [NBLK-1:0] pre_p;
    logic [PW-1:0]   sum_w;
    logic            c;
    logic            c_msb;

    // Block-level generate/propagate.
    always_comb begin
        blk_g = '0;
        blk_p = '1;
        for (int bi = 0; bi < NBLK; bi++) begin
            for (int j = 0; j < BLK; j++) begin
                blk_g[bi] = g_pad[bi*BLK+j] | (p_pad[bi*BLK+j] & blk_g[bi]);
                blk_p[bi] = blk_p[bi] & p_pad[bi*BLK+j];
            end
        end
    end

    // Prefix tree over blocks; carry_in is folded into block 0 so pre_g[bi]
    // is directly the carry out of block bi. Descending bi keeps level-(d-1)
    // values available for the b-d operand.
    always_comb begin
        pre_g    = blk_g;
        pre_p    = blk_p;
        pre_g[0] = blk_g[0] | (blk_p[0] & carry_in);
        for (int d = 1; d < NBLK; d = d * 2) begin
            for (int bi = NBLK - 1; bi >= d; bi--) begin
                pre_g[bi] = pre_g[bi] | (pre_p[bi] & pre_g[bi-d]);
                pre_p[bi] = pre_p[bi] & pre_p[bi-d];
            end
        end
    end

    // Sparse part: ripple inside each block from its prefix carry.
    always_comb begin
        sum_w = '0;
        c     = 1'b0;
        c_msb = 1'b0;
        for (int bi = 0; bi < NBLK; bi++) begin
            if (bi == 0) begin
                c = carry_in;
            end else begin
                c = pre_g[bi-1];
            end
            for (int j = 0; j < BLK; j++) begin
                if (bi*BLK + j == NB - 1) begin
                    c_msb = c;
                end
                sum_w[bi*BLK+j] = p_pad[bi*BLK+j] ^ c;
                c = g_pad[bi*BLK+j] | (p_pad[bi*BLK+j] & c);
            end
        end
    end

    // Pad sum bits carry no information.
    logic unused_sum_pad;
    assign unused_sum_pad = ^sum_w;

    assign sum       = sum_w[N_BIT-1:0];
    assign carry_out = pre_g[NBLK-1];
    assign overflow  = c_msb ^ pre_g[NBLK-1];

endmodule

// File: rtl/chunked_wide_adder.sv
// ---------------------------------------------------------------------------
// chunked_wide_adder
//   Multi-cycle W = N_BIT*N_CHUNKS bit adder. An accepted operation is summed
//   LSB chunk first, one chunk per cycle, through a single sparse_tree_adder;
//   the inter-chunk carry lives in carry_q. The result is presented
//   N_CHUNKS cycles after the accept edge and held until out_ready.
//   Ports:
//     clk   in   single clock, rising edge
//     rst   in   asynchronous, active-high reset
//     bus   slave modport of chunked_wide_adder_if (W wide):
//           in_valid/in_ready, operand_1, operand_2, carry_in,
//           out_valid/out_ready, sum, carry_out, overflow
// ---------------------------------------------------------------------------
module chunked_wide_adder
    import wide_add_pkg::*;
#(
    parameter int unsigned N_BIT    = 32,
    parameter int unsigned N_CHUNKS = 4
) (
    input logic                 clk,
    input logic                 rst,
    chunked_wide_adder_if.slave bus
);

    localparam int unsigned W     = N_BIT * N_CHUNKS;
    localparam int unsigned CNT_W = chunk_cnt_width(N_CHUNKS);
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N_CHUNKS - 1);

    wide_add_state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic [W-1:0]     op1_q;
    logic [W-1:0]     op2_q;
    logic [W-1:0]     res_q;
    logic             ovf_q;

    logic [N_BIT-1:0] add_sum;
    logic             add_cout;
    logic             add_ovf;

    logic accept;
    logic last_chunk;

    assign accept     = (state_q == IDLE) && bus.in_valid;
    assign last_chunk = (cnt_q == LAST_CHUNK);

    sparse_tree_adder #(
        .N_BIT(N_BIT)
    ) u_adder (
        .clk      (clk),
        .a        (op1_q[N_BIT-1:0]),
        .b        (op2_q[N_BIT-1:0]),
        .carry_in (carry_q),
        .sum      (add_sum),
        .carry_out(add_cout),
        .overflow (add_ovf)
    );

    // FSM: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid) state_d = RUN;
            RUN:     if (last_chunk) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: handshake outputs. in_ready stays low while reset is held.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state_q)
            IDLE:    bus.in_ready  = ~rst;
            DONE:    bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand shift regs, chunk counter, carry and result regs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            op1_q   <= bus.operand_1;
            op2_q   <= bus.operand_2;
            carry_q <= bus.carry_in;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            op1_q   <= op1_q >> N_BIT;
            op2_q   <= op2_q >> N_BIT;
            // Chunk sums enter from the top; after N_CHUNKS shifts chunk 0 is at the LSBs.
            res_q   <= (res_q >> N_BIT) | (W'(add_sum) << (W - N_BIT));
            carry_q <= add_cout;
            if (last_chunk) begin
                ovf_q <= add_ovf;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Results are straight from registers, so they cannot glitch while held in DONE.
    assign bus.sum       = res_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_chunked_wide_adder.sv
// ---------------------------------------------------------------------------
// tb_chunked_wide_adder
//   Directed and randomized checks of chunked_wide_adder (N_BIT=8, N_CHUNKS=4)
//   against a plain-arithmetic golden model and an expected-result queue.
// ---------------------------------------------------------------------------
module tb_chunked_wide_adder;

    localparam int unsigned N_BIT    = 8;
    localparam int unsigned N_CHUNKS = 4;
    localparam int unsigned W        = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_emit = 0;

    logic [33:0] exp_q[$];

    chunked_wide_adder_if #(.W(W)) bus ();

    chunked_wide_adder #(
        .N_BIT   (N_BIT),
        .N_CHUNKS(N_CHUNKS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Golden model packed as {carry_out, overflow, sum}.
    function automatic logic [33:0] golden(input logic [31:0] a, input logic [31:0] b,
                                           input logic ci);
        logic [32:0] full;
        logic        ovf;
        full = {1'b0, a} + {1'b0, b} + {32'd0, ci};
        ovf  = (a[31] == b[31]) && (full[31] != a[31]);
        return {full[32], ovf, full[31:0]};
    endfunction

    function automatic logic [33:0] observed();
        return {bus.carry_out, bus.overflow, bus.sum};
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0000_0000;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'h7FFF_FFFF;
            default: v = $urandom();
        endcase
        return v;
    endfunction

    // Present an operation and return 1 time unit after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ci);
        int n;
        n = 0;
        @(negedge clk);
        bus.operand_1 = a;
        bus.operand_2 = b;
        bus.carry_in  = ci;
        bus.in_valid  = 1'b1;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.operand_1 = '0;
        bus.operand_2 = '0;
        bus.carry_in  = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic ci, input int hold);
        int          lat;
        logic [33:0] exp;
        exp = golden(a, b, ci);
        bus.out_ready = 1'b0;
        send(a, b, ci);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(N_CHUNKS));
        check({tag, "_result"}, 64'(observed()), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
            check({tag, "_hold_result"}, 64'(observed()), 64'(exp));
            check({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_valid_drops"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_in_ready_back"}, 64'(bus.in_ready), 64'd1);
    endtask

    // Sampled mid-cycle; accept and emit can never coincide in this design.
    task automatic monitor();
        if (bus.out_valid && bus.out_ready) begin
            n_emit++;
            check("rand_result_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                check("rand_result", 64'(observed()), 64'(exp_q.pop_front()));
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(golden(bus.operand_1, bus.operand_2, bus.carry_in));
            n_acc++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int valid_seen;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.operand_1 = '0;
        bus.operand_2 = '0;
        bus.carry_in  = 1'b0;

        // Reset state
        #12;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_result", 64'(observed()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);

        // Directed arithmetic corners
        directed("all_ones_cin", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
        directed("pos_overflow", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
        directed("neg_overflow", 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
        // Backpressure: result held for 5 cycles
        directed("backpressure", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 5);

        // Reset in the middle of RUN (k==2): nothing may be emitted
        bus.out_ready = 1'b0;
        send(32'h1122_3344, 32'h0101_0101, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrun_rst_sum", 64'(bus.sum), 64'd0);
        check("midrun_rst_carry_out", 64'(bus.carry_out), 64'd0);
        check("midrun_rst_overflow", 64'(bus.overflow), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        valid_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) valid_seen++;
        end
        check("midrun_rst_no_output", 64'(valid_seen), 64'd0);
        directed("after_reset", 32'h0000_0010, 32'h0000_0020, 1'b0, 0);

        // Randomized traffic with random in_valid / out_ready
        for (int cyc = 0; cyc < 12000; cyc++) begin
            @(negedge clk);
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.operand_1 = rand_operand();
            bus.operand_2 = rand_operand();
            bus.carry_in  = 1'($urandom_range(0, 1));
            #1;
            monitor();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            #1;
            monitor();
        end
        check("rand_accept_vs_emit", 64'(n_emit), 64'(n_acc));
        check("rand_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
